pulse_timebase_ctrl: RTL and testbench

- Central timebase controller for the SoC.
- Divides the system clock into a 1us tick, then chains it into 1ms and 1s ticks.
- Schedules NTMR software timers. Each timer has a selectable tick source, one-shot or periodic mode, and a sticky interrupt.
- Sits between the register block (config/start/stop/clear strobes) and the interrupt controller and peripherals that consume the tick pulses.

---
 rtl/pulse_timebase_ctrl.sv | 99 +++++++++
 tb/tb_pulse_timebase_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_timebase_ctrl.sv
// pulse_timebase_ctrl: us/ms/s tick generator plus NTMR one-shot/periodic software timers
module pulse_timebase_ctrl #(
  parameter int US_DIV_W = 8,
  parameter int TMR_W    = 16,
  parameter int NTMR     = 4,
  parameter int MS_MAX   = 999,
  parameter int S_MAX    = 999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_enable,
  input  logic [US_DIV_W-1:0]   cfg_us_div,
  input  logic [NTMR-1:0]       tmr_start,
  input  logic [NTMR-1:0]       tmr_stop,
  input  logic [NTMR-1:0]       tmr_periodic,
  input  logic [2*NTMR-1:0]     tmr_src,
  input  logic [TMR_W*NTMR-1:0] tmr_load,
  input  logic [NTMR-1:0]       tmr_irq_clr,
  output logic                  pulse_1us_o,
  output logic                  pulse_1ms_o,
  output logic                  pulse_1s_o,
  output logic [NTMR-1:0]       tmr_busy_o,
  output logic [NTMR-1:0]       tmr_irq_o,
  output logic [TMR_W*NTMR-1:0] tmr_cnt_o
);
  typedef enum logic {IDLE, RUN} state_t;
  logic [US_DIV_W-1:0] us_cnt;
  logic [9:0] ms_cnt, s_cnt;
  assign pulse_1us_o = !reset && cfg_enable && (us_cnt >= cfg_us_div);
  assign pulse_1ms_o = pulse_1us_o && (ms_cnt == 10'(MS_MAX));
  assign pulse_1s_o  = pulse_1ms_o && (s_cnt == 10'(S_MAX));
  // prescaler and chained ms/s dividers; disable restarts the division from 0
  always_ff @(posedge clk) begin
    if (reset || !cfg_enable) begin
      us_cnt <= '0;
      ms_cnt <= '0;
      s_cnt  <= '0;
    end else if (pulse_1us_o) begin
      us_cnt <= '0;
      ms_cnt <= pulse_1ms_o ? '0 : ms_cnt + 10'd1;
      if (pulse_1ms_o) s_cnt <= pulse_1s_o ? '0 : s_cnt + 10'd1;
    end else begin
      us_cnt <= us_cnt + 1'b1;
    end
  end
  for (genvar g = 0; g < NTMR; g++) begin : ch
    state_t st_q, st_d;
    logic [TMR_W-1:0] cnt_q, cnt_d, ld_q, ld_d, ld_new;
    logic [1:0] src_q, src_d;
    logic per_q, per_d, irq_q, irq_d, tick, expire;
    assign ld_new = (tmr_load[g*TMR_W +: TMR_W] == '0) ? TMR_W'(1) : tmr_load[g*TMR_W +: TMR_W];
    assign tick = src_q == 2'd0 ? pulse_1us_o : src_q == 2'd1 ? pulse_1ms_o : src_q == 2'd2 ? pulse_1s_o : 1'b0;
    // next state: start beats stop beats expiry; an expiry set beats a same-clk clear
    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      ld_d   = ld_q;
      src_d  = src_q;
      per_d  = per_q;
      expire = 1'b0;
      if (tmr_start[g]) begin
        ld_d  = ld_new;
        src_d = tmr_src[2*g +: 2];
        per_d = tmr_periodic[g];
        cnt_d = ld_new;
        st_d  = RUN;
      end else if (tmr_stop[g]) begin
        st_d  = IDLE;
        cnt_d = '0;
      end else if (st_q == RUN && tick) begin
        expire = cnt_q == TMR_W'(1);
        cnt_d  = !expire ? cnt_q - TMR_W'(1) : per_q ? ld_q : '0;
        st_d   = (expire && !per_q) ? IDLE : RUN;
      end
      irq_d = expire | (irq_q & ~tmr_irq_clr[g]);
    end
    // channel state, count, shadow config and sticky irq
    always_ff @(posedge clk) begin
      if (reset) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        ld_q  <= '0;
        src_q <= '0;
        per_q <= 1'b0;
        irq_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        ld_q  <= ld_d;
        src_q <= src_d;
        per_q <= per_d;
        irq_q <= irq_d;
      end
    end
    assign tmr_busy_o[g] = st_q == RUN;
    assign tmr_irq_o[g] = irq_q;
    assign tmr_cnt_o[g*TMR_W +: TMR_W] = cnt_q;
  end
endmodule

// File: tb/tb_pulse_timebase_ctrl.sv
// tb_pulse_timebase_ctrl: directed and random checks against a tick-count reference model
module tb_pulse_timebase_ctrl;
  localparam int NTMR = 4, TMR_W = 16, MS_MAX = 999, S_MAX = 4;
  logic clk = 0, reset, cfg_enable;
  logic [7:0] cfg_us_div;
  logic [NTMR-1:0] tmr_start, tmr_stop, tmr_periodic, tmr_irq_clr;
  logic [2*NTMR-1:0] tmr_src;
  logic [TMR_W*NTMR-1:0] tmr_load;
  logic pulse_1us_o, pulse_1ms_o, pulse_1s_o;
  logic [NTMR-1:0] tmr_busy_o, tmr_irq_o;
  logic [TMR_W*NTMR-1:0] tmr_cnt_o;
  int errors = 0, checks = 0;
  int n = 0, us_k = 0, ms_k = 0, first_ms = -1, first_s = -1;
  int m_cnt [NTMR], m_ld [NTMR], m_src [NTMR];
  bit m_run [NTMR], m_per [NTMR], m_irq [NTMR];
  pulse_timebase_ctrl #(.S_MAX(S_MAX)) dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_us_div(cfg_us_div),
    .tmr_start(tmr_start), .tmr_stop(tmr_stop), .tmr_periodic(tmr_periodic),
    .tmr_src(tmr_src), .tmr_load(tmr_load), .tmr_irq_clr(tmr_irq_clr),
    .pulse_1us_o(pulse_1us_o), .pulse_1ms_o(pulse_1ms_o), .pulse_1s_o(pulse_1s_o),
    .tmr_busy_o(tmr_busy_o), .tmr_irq_o(tmr_irq_o), .tmr_cnt_o(tmr_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    bit eu, em, es, tk;
    int L;
    logic [NTMR-1:0] eb, ei;
    logic [TMR_W*NTMR-1:0] ec;
    #1;
    eu = 0; em = 0; es = 0;
    if (!reset && cfg_enable) begin
      eu = (n % (int'(cfg_us_div) + 1)) == int'(cfg_us_div);
      if (eu) us_k++;
      em = eu && (us_k % (MS_MAX + 1) == 0);
      if (em) ms_k++;
      es = em && (ms_k % (S_MAX + 1) == 0);
      if (pulse_1ms_o && first_ms < 0) first_ms = n;
      if (pulse_1s_o && first_s < 0) first_s = n;
      n++;
    end else begin
      n = 0; us_k = 0; ms_k = 0;
    end
    for (int c = 0; c < NTMR; c++) begin
      eb[c] = m_run[c];
      ei[c] = m_irq[c];
      ec[c*TMR_W +: TMR_W] = m_cnt[c][TMR_W-1:0];
    end
    chk("pulse_1us", pulse_1us_o, eu);
    chk("pulse_1ms", pulse_1ms_o, em);
    chk("pulse_1s", pulse_1s_o, es);
    chk("busy", tmr_busy_o, eb);
    chk("irq", tmr_irq_o, ei);
    chk("cnt", tmr_cnt_o, ec);
    for (int c = 0; c < NTMR; c++) begin
      if (reset) begin
        m_cnt[c] = 0; m_ld[c] = 0; m_src[c] = 0; m_run[c] = 0; m_per[c] = 0; m_irq[c] = 0;
      end else if (tmr_start[c]) begin
        L = int'(tmr_load[c*TMR_W +: TMR_W]);
        m_ld[c] = (L == 0) ? 1 : L;
        m_cnt[c] = m_ld[c];
        m_src[c] = int'(tmr_src[2*c +: 2]);
        m_per[c] = tmr_periodic[c];
        m_run[c] = 1;
        if (tmr_irq_clr[c]) m_irq[c] = 0;
      end else if (tmr_stop[c]) begin
        m_run[c] = 0; m_cnt[c] = 0;
        if (tmr_irq_clr[c]) m_irq[c] = 0;
      end else begin
        tk = (m_src[c] == 0) ? eu : (m_src[c] == 1) ? em : (m_src[c] == 2) ? es : 1'b0;
        if (tmr_irq_clr[c]) m_irq[c] = 0;
        if (m_run[c] && tk) begin
          m_cnt[c]--;
          if (m_cnt[c] == 0) begin
            m_irq[c] = 1;
            if (m_per[c]) m_cnt[c] = m_ld[c];
            else m_run[c] = 0;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    tmr_start = '0; tmr_stop = '0; tmr_irq_clr = '0;
  endtask
  initial begin
    reset = 1; cfg_enable = 0; cfg_us_div = 0;
    tmr_start = '0; tmr_stop = '0; tmr_periodic = '0; tmr_irq_clr = '0; tmr_src = '0; tmr_load = '0;
    for (int c = 0; c < NTMR; c++) begin
      m_cnt[c] = 0; m_ld[c] = 0; m_src[c] = 0; m_run[c] = 0; m_per[c] = 0; m_irq[c] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    repeat (3) cyc();
    reset = 0; cfg_enable = 1; cfg_us_div = 3;
    repeat (4100) cyc();
    chk("first_1ms_div3", 64'(first_ms), 64'd3999);
    cfg_enable = 0; cyc();
    cfg_us_div = 0; cfg_enable = 1; first_ms = -1;
    repeat (5200) cyc();
    chk("first_1ms_div0", 64'(first_ms), 64'd999);
    chk("first_1s_div0", 64'(first_s), 64'd4999);
    repeat (2345) cyc();
    cfg_enable = 0; repeat (3) cyc();
    cfg_enable = 1; repeat (1500) cyc();
    cfg_enable = 0; cyc();
    cfg_us_div = 1; cfg_enable = 1;
    tmr_start[0] = 1; tmr_load[15:0] = 5; tmr_src[1:0] = 0; tmr_periodic[0] = 0;
    cyc();
    chk("ch0_cnt_load", tmr_cnt_o[15:0], 5);
    repeat (12) cyc();
    chk("ch0_irq", tmr_irq_o[0], 1);
    chk("ch0_busy", tmr_busy_o[0], 0);
    chk("ch0_cnt_end", tmr_cnt_o[15:0], 0);
    tmr_irq_clr[0] = 1; cyc();
    chk("ch0_irq_clr", tmr_irq_o[0], 0);
    cfg_enable = 0; cyc();
    cfg_us_div = 0; cfg_enable = 1;
    tmr_start[1] = 1; tmr_load[31:16] = 2; tmr_src[3:2] = 1; tmr_periodic[1] = 1;
    cyc();
    repeat (2100) cyc();
    chk("ch1_irq_2ms", tmr_irq_o[1], 1);
    chk("ch1_busy_2ms", tmr_busy_o[1], 1);
    tmr_irq_clr[1] = 1; cyc();
    chk("ch1_irq_clr", tmr_irq_o[1], 0);
    repeat (1950) cyc();
    chk("ch1_irq_4ms", tmr_irq_o[1], 1);
    chk("ch1_busy_4ms", tmr_busy_o[1], 1);
    tmr_stop[1] = 1; cyc();
    chk("ch1_stop_busy", tmr_busy_o[1], 0);
    chk("ch1_stop_cnt", tmr_cnt_o[31:16], 0);
    tmr_start[2] = 1; tmr_load[47:32] = 0; tmr_src[5:4] = 0; tmr_periodic[2] = 0;
    cyc();
    chk("ch2_load0_cnt", tmr_cnt_o[47:32], 1);
    cyc();
    chk("ch2_load0_irq", tmr_irq_o[2], 1);
    chk("ch2_load0_busy", tmr_busy_o[2], 0);
    tmr_start[2] = 1; tmr_stop[2] = 1; tmr_load[47:32] = 3;
    cyc();
    chk("ch2_startstop_busy", tmr_busy_o[2], 1);
    chk("ch2_startstop_cnt", tmr_cnt_o[47:32], 3);
    tmr_irq_clr[2] = 1; cyc();
    cyc();
    chk("ch2_cnt1", tmr_cnt_o[47:32], 1);
    tmr_irq_clr[2] = 1; cyc();
    chk("ch2_set_beats_clr", tmr_irq_o[2], 1);
    tmr_start[3] = 1; tmr_load[63:48] = 3; tmr_src[7:6] = 0; tmr_periodic[3] = 1;
    repeat (3) cyc();
    chk("ch3_cnt1", tmr_cnt_o[63:48], 1);
    tmr_start[3] = 1; tmr_load[63:48] = 7;
    cyc();
    chk("ch3_restart_cnt", tmr_cnt_o[63:48], 7);
    chk("ch3_restart_noirq", tmr_irq_o[3], 0);
    tmr_load[63:48] = 2;
    repeat (7) cyc();
    chk("ch3_reload_cnt", tmr_cnt_o[63:48], 7);
    chk("ch3_reload_irq", tmr_irq_o[3], 1);
    tmr_start[3] = 1; tmr_load[63:48] = 4; tmr_src[7:6] = 3;
    repeat (11) cyc();
    chk("ch3_src11_cnt", tmr_cnt_o[63:48], 4);
    chk("ch3_src11_busy", tmr_busy_o[3], 1);
    for (int i = 0; i < 4000; i++) begin
      if (!cfg_enable) cfg_enable = 1;
      else if ($urandom_range(0, 199) == 0) begin
        cfg_enable = 0;
        cfg_us_div = 8'($urandom_range(0, 3));
      end
      for (int c = 0; c < NTMR; c++) begin
        tmr_start[c] = $urandom_range(0, 40) == 0;
        tmr_stop[c] = $urandom_range(0, 150) == 0;
        tmr_irq_clr[c] = $urandom_range(0, 20) == 0;
        tmr_periodic[c] = 1'($urandom_range(0, 1));
        tmr_src[2*c +: 2] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        tmr_load[c*TMR_W +: TMR_W] = 16'($urandom_range(0, 6));
      end
      cyc();
    end
    reset = 1; cyc();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
